aes_192_ctr_seq: RTL and testbench
==================================

# aes_192_ctr_seq

Streaming CTR-mode sequencer that sits directly upstream of the `aes_192_sed` encrypt/decrypt stage.
- Accepts a key/IV load, then a valid/ready stream of 128-bit plain- or cipher-text blocks.
- For each block it drives the stage's `state`/`p_c_text`/`key`, produces a clean 0→1 `start` edge, and waits for `out_valid`.
- It registers the XORed result onto a valid/ready output stream and increments the counter.
- It turns the single-shot, hold-inputs-until-done stage into a back-pressured block stream.

## Interface
- `CTR_W`, default 32: width of the incrementing counter field, taken from IV bits [CTR_W-1:0]; legal range 1..128.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cfg_load`  in  1  pulse; captures `cfg_key` and `cfg_iv`; acted on only in IDLE.
- `cfg_key`  in  192  AES-192 key.
- `cfg_iv`  in  128  initial counter block.
- `in_valid`  in  1  input block valid.
- `in_ready`  out  1  sequencer accepts an input block.
- `in_data`  in  128  plain/cipher text block.
- `in_last`  in  1  marks the final block of a message; passed through to `out_last`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  128  result block.
- `out_last`  out  1  copy of the `in_last` that was accepted with this block.
- `busy`  out  1  high in any state other than IDLE.
- `core_start`  out  1  drives the stage's `start`.
- `core_state`  out  128  drives the stage's `state`: the current counter block.
- `core_key`  out  192  drives the stage's `key`: the registered key.
- `core_text`  out  128  drives the stage's `p_c_text`: the registered input block.
- `core_out`  in  128  from the stage's `out`.
- `core_out_valid`  in  1  from the stage's `out_valid`.

## Operation
- **Reset values:** all outputs 0; `loaded`=0; state IDLE.
- **IDLE**
  - `in_ready` = `loaded`.
  - `cfg_load`=1 captures key and IV into the counter register and sets `loaded`=1. `in_ready` stays 0 in that cycle.
  - `in_valid & in_ready` latches `in_data`/`in_last` into `core_text` and a last flag, then goes to ARM.
  - If `cfg_load` and an input handshake would coincide, `cfg_load` wins, because `in_ready` is 0 that cycle.
- **ARM** (1 cycle): `core_start`=0, which guarantees a rising edge. Go to FIRE.
- **FIRE** (1 cycle): `core_start`=1; `seen_low`←0. Go to WAIT.
- **WAIT**
  - `core_start` is held at 1.
  - `core_out_valid`=0 sets `seen_low`.
  - `core_out_valid`=1 with `seen_low`=1 (this includes the same-cycle case where the registered `seen_low` is already 1) does all of the following, then goes to OUT:
    - registers `core_out` into `out_data`;
    - sets `out_valid`=1;
    - increments the counter;
    - drops `core_start` to 0 on the next cycle.
  - `core_out_valid`=1 with `seen_low`=0 is a stale flag from the previous operation and is ignored.
- **OUT**
  - `out_valid` and `out_data` are held stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- **Counter increment**
  - Bits [CTR_W-1:0] increment modulo 2^CTR_W; bits [127:CTR_W] are unchanged.
  - All-ones wraps to 0 with no carry into the upper bits.
  - With CTR_W=128 the whole block wraps.
- **Input stability:** `core_key`, `core_state` and `core_text` change only in IDLE, so they are stable from ARM through WAIT.
- **`in_last`:** informational only. The counter persists across messages and is restarted only by `cfg_load`.
- **`cfg_load` outside IDLE:** ignored; no error.
- **Reset mid-operation:** any state returns to IDLE with outputs 0 and `loaded`=0, and `core_start` drops on the next edge. Any pending stage result is discarded; after reset a fresh `cfg_load` is required.

## Timing
- Input handshake at cycle T:
  - T+1: ARM
  - T+2: FIRE (`core_start` rises)
  - T+3 onward: WAIT
- If the stage raises `core_out_valid` L cycles after the `start` edge (L ≥ 1, with `seen_low` observed), `out_valid` rises at T+2+L+1.
- Earliest next `in_ready`: the cycle after the output handshake.
- Throughput: one block in flight. No overlap, because the stage cannot accept new inputs before `out_valid`.
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from `out_ready`/`in_valid`. `out_data` is a register.

## Structure
- **Shared package `aes_ctr_pkg`:**
  - widths BLK_W=128 and KEY_W=192;
  - state enum IDLE/ARM/FIRE/WAIT/OUT;
  - type for the 128-bit counter block.
- **Sub-module `aes_ctr_inc`:** combinational, parameter CTR_W; maps a counter block to the next counter block. Reused by any future CTR wrappers.
- **Instantiation:** the sequencer FSM, key/IV/data registers and output register are in the top. The `aes_192_sed` instance is external, connected by the `core_*` ports.

## Test plan
- **Load, one block:**
  - stimulus: reset; `cfg_load` with IV=0x0…0; key=0; a stage model with L=12; `in_data`=0.
  - response: `out_data` = AES192(0,0); `core_state`=0 during WAIT; counter=1 afterwards; `out_valid` 15 cycles after the input handshake.
- **Start edge and stale valid:**
  - stimulus: stage model holds `core_out_valid`=1 at FIRE, drops it for 3 cycles, then raises it.
  - response: capture only on the re-rise; `core_start` goes 0 in ARM and 1 in FIRE.
- **Back-pressure:**
  - stimulus: `out_ready`=0 for 20 cycles.
  - response: `out_data` stable, `in_ready`=0 throughout; the next block is accepted only after the output handshake; 4-block stream matches the CTR reference model with `out_last` on block 4.
- **Wrap:**
  - stimulus: CTR_W=32; IV=0xAABBCCDD_00000000_11111111_FFFFFFFF; two blocks.
  - response: second `core_state`=0xAABBCCDD_00000000_11111111_00000000.
- **Reset mid-WAIT:**
  - stimulus: assert `rst` for one cycle during WAIT.
  - response: next cycle `core_start`=0, `busy`=0, `in_ready`=0; no `out_valid`; `in_ready` returns only after `cfg_load`.
- **`cfg_load` while busy:**
  - stimulus: pulse `cfg_load` with a new IV during WAIT.
  - response: ignored; the counter continues from the old IV+1.

Source files
------------

// File: rtl/aes_ctr_pkg.sv
// Shared widths, sequencer state encoding and counter-block type for the AES CTR wrappers.
package aes_ctr_pkg;

    localparam int unsigned BLK_W = 128;
    localparam int unsigned KEY_W = 192;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        WAIT,
        OUT
    } seq_state_e;

    typedef logic [BLK_W-1:0] ctr_blk_t;

endpackage

// File: rtl/aes_192_ctr_seq_if.sv
// Bundle of config, input/output stream and encrypt-stage signals around the CTR sequencer.
interface aes_192_ctr_seq_if;

    logic                            cfg_load;
    logic [aes_ctr_pkg::KEY_W-1:0]   cfg_key;
    logic [aes_ctr_pkg::BLK_W-1:0]   cfg_iv;

    logic                            in_valid;
    logic                            in_ready;
    logic [aes_ctr_pkg::BLK_W-1:0]   in_data;
    logic                            in_last;

    logic                            out_valid;
    logic                            out_ready;
    logic [aes_ctr_pkg::BLK_W-1:0]   out_data;
    logic                            out_last;

    logic                            busy;

    logic                            core_start;
    logic [aes_ctr_pkg::BLK_W-1:0]   core_state;
    logic [aes_ctr_pkg::KEY_W-1:0]   core_key;
    logic [aes_ctr_pkg::BLK_W-1:0]   core_text;
    logic [aes_ctr_pkg::BLK_W-1:0]   core_out;
    logic                            core_out_valid;

    // Environment side: source of config/input blocks, sink of results, and the stage itself.
    modport master (
        output cfg_load, cfg_key, cfg_iv,
        output in_valid, in_data, in_last,
        input  in_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  busy,
        input  core_start, core_state, core_key, core_text,
        output core_out, core_out_valid
    );

    // Sequencer side.
    modport slave (
        input  cfg_load, cfg_key, cfg_iv,
        input  in_valid, in_data, in_last,
        output in_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output busy,
        output core_start, core_state, core_key, core_text,
        input  core_out, core_out_valid
    );

endinterface

// File: rtl/aes_ctr_inc.sv
// Next CTR counter block: low CTR_W bits increment modulo 2^CTR_W, upper bits pass through.
module aes_ctr_inc
    import aes_ctr_pkg::*;
#(
    parameter int unsigned CTR_W = 32
) (
    input  ctr_blk_t ctr,
    output ctr_blk_t ctr_next
);

    if (CTR_W >= BLK_W) begin : g_full
        assign ctr_next = ctr + ctr_blk_t'(1);
    end else begin : g_part
        logic [CTR_W-1:0] low_next;
        assign low_next = ctr[CTR_W-1:0] + CTR_W'(1);
        assign ctr_next = {ctr[BLK_W-1:CTR_W], low_next};
    end

endmodule

// File: rtl/aes_192_ctr_seq.sv
// CTR-mode sequencer feeding a single-shot AES-192 encrypt/decrypt stage as a back-pressured stream.
module aes_192_ctr_seq
    import aes_ctr_pkg::*;
#(
    parameter int unsigned CTR_W = 32
) (
    input logic              clk,
    input logic              rst,
    aes_192_ctr_seq_if.slave bus
);

    seq_state_e         state_q, state_d;
    logic               loaded_q;
    logic [KEY_W-1:0]   key_q;
    ctr_blk_t           ctr_q, ctr_next;
    logic [BLK_W-1:0]   text_q;
    logic               last_q;
    logic               seen_low_q;
    logic [BLK_W-1:0]   out_data_q;
    logic               out_last_q;

    logic in_ready, in_hs, capture;

    aes_ctr_inc #(
        .CTR_W (CTR_W)
    ) u_inc (
        .ctr      (ctr_q),
        .ctr_next (ctr_next)
    );

    // cfg_load takes priority over an input handshake in the same cycle.
    assign in_ready = (state_q == IDLE) && loaded_q && !bus.cfg_load;
    assign in_hs    = bus.in_valid && in_ready;
    // Only a valid that follows an observed low belongs to the current operation.
    assign capture  = (state_q == WAIT) && bus.core_out_valid && seen_low_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_hs) state_d = ARM;
            ARM:     state_d = FIRE;
            FIRE:    state_d = WAIT;
            WAIT:    if (capture) state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = in_ready;
        bus.out_valid  = (state_q == OUT);
        bus.busy       = (state_q != IDLE);
        bus.core_start = (state_q == FIRE) || (state_q == WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loaded_q   <= 1'b0;
            key_q      <= '0;
            ctr_q      <= '0;
            text_q     <= '0;
            last_q     <= 1'b0;
            seen_low_q <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (bus.cfg_load) begin
                    key_q    <= bus.cfg_key;
                    ctr_q    <= bus.cfg_iv;
                    loaded_q <= 1'b1;
                end else if (in_hs) begin
                    text_q <= bus.in_data;
                    last_q <= bus.in_last;
                end
            end

            if (state_q == FIRE) begin
                seen_low_q <= 1'b0;
            end else if ((state_q == WAIT) && !bus.core_out_valid) begin
                seen_low_q <= 1'b1;
            end

            if (capture) begin
                out_data_q <= bus.core_out;
                out_last_q <= last_q;
                ctr_q      <= ctr_next;
            end
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.core_state = ctr_q;
    assign bus.core_key   = key_q;
    assign bus.core_text  = text_q;

endmodule

// File: tb/tb_aes_192_ctr_seq.sv
// Directed bench for aes_192_ctr_seq with a latency-programmable stand-in for the encrypt stage.
module tb_aes_192_ctr_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Stage model knobs: result after lat cycles; stale valid held for stale_hold cycles.
    int unsigned lat        = 12;
    int unsigned stale_hold = 0;

    aes_192_ctr_seq_if bus ();

    aes_192_ctr_seq #(
        .CTR_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: keystream is a fixed mix of counter and key, XORed with the text.
    function automatic logic [127:0] fk(input logic [127:0] s, input logic [191:0] k,
                                        input logic [127:0] t);
        return {s[63:0], s[127:64]} ^ k[127:0] ^ {k[191:128], ~k[191:128]}
               ^ 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0 ^ t;
    endfunction

    logic        start_prev;
    logic        active;
    int unsigned since;

    always @(posedge clk) begin
        if (rst) begin
            start_prev         <= 1'b0;
            active             <= 1'b0;
            since              <= 0;
            bus.core_out_valid <= 1'b0;
            bus.core_out       <= '0;
        end else begin
            start_prev <= bus.core_start;
            if (bus.core_start && !start_prev) begin
                active <= 1'b1;
                since  <= 1;
                if (stale_hold == 0) bus.core_out_valid <= 1'b0;
            end else if (active) begin
                since <= since + 1;
                if (since + 1 == lat) begin
                    bus.core_out_valid <= 1'b1;
                    bus.core_out <= fk(bus.core_state, bus.core_key, bus.core_text);
                end else if (since + 1 > stale_hold && since + 1 < lat) begin
                    bus.core_out_valid <= 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [191:0] k, input logic [127:0] iv);
        bus.cfg_load = 1'b1;
        bus.cfg_key  = k;
        bus.cfg_iv   = iv;
        tick();
        bus.cfg_load = 1'b0;
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic l);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Sends one block; reports start at ARM/FIRE, counter in WAIT, cycles from handshake to out_valid.
    task automatic run_block(input logic [127:0] d, input logic l, input bit ack,
                             output logic s_arm, output logic s_fire, output logic [127:0] st_wait,
                             output int cyc, output logic [127:0] od, output logic ol);
        send(d, l);
        s_arm = bus.core_start;
        tick();
        s_fire = bus.core_start;
        tick();
        st_wait = bus.core_state;
        cyc = 3;
        while (!bus.out_valid && cyc < 300) begin
            tick();
            cyc++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_timeout: out_valid=%b required 1", bus.out_valid);
        end
        od = bus.out_data;
        ol = bus.out_last;
        if (ack) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    logic         s_arm, s_fire, ol;
    logic [127:0] st_wait, od;
    int           cyc;

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks += 6;
        if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        if (bus.core_start !== 1'b0) begin errors++; $display("FAIL rst_core_start: got %b required 0", bus.core_start); end
        if (bus.out_data !== 128'h0) begin errors++; $display("FAIL rst_out_data: got %h required 0", bus.out_data); end
        if (bus.core_state !== 128'h0) begin errors++; $display("FAIL rst_core_state: got %h required 0", bus.core_state); end
    endtask

    task automatic test_one_block();
        lat = 12;
        stale_hold = 0;
        load(192'h0, 128'h0);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready: got %b required 1", bus.in_ready); end
        run_block(128'h0, 1'b0, 1'b1, s_arm, s_fire, st_wait, cyc, od, ol);
        checks += 7;
        if (s_arm !== 1'b0)  begin errors++; $display("FAIL one_arm_start: got %b required 0", s_arm); end
        if (s_fire !== 1'b1) begin errors++; $display("FAIL one_fire_start: got %b required 1", s_fire); end
        if (st_wait !== 128'h0) begin errors++; $display("FAIL one_wait_state: got %h required 0", st_wait); end
        if (cyc != 15) begin errors++; $display("FAIL one_latency: got %0d required 15", cyc); end
        if (od !== 128'h0F1E2D3C_4B5A6978_78695A4B_3C2D1E0F)
            begin errors++; $display("FAIL one_out_data: got %h required 0f1e2d3c4b5a697878695a4b3c2d1e0f", od); end
        if (ol !== 1'b0) begin errors++; $display("FAIL one_out_last: got %b required 0", ol); end
        if (bus.core_state !== 128'h1) begin errors++; $display("FAIL one_ctr_after: got %h required 1", bus.core_state); end
    endtask

    task automatic test_stale_valid();
        lat = 5;
        stale_hold = 1;
        run_block(128'hDEADBEEF_00000000_CAFEF00D_12345678, 1'b1, 1'b1,
                  s_arm, s_fire, st_wait, cyc, od, ol);
        checks += 5;
        if (s_arm !== 1'b0)  begin errors++; $display("FAIL stale_arm_start: got %b required 0", s_arm); end
        if (s_fire !== 1'b1) begin errors++; $display("FAIL stale_fire_start: got %b required 1", s_fire); end
        if (cyc != 8) begin errors++; $display("FAIL stale_latency: got %0d required 8", cyc); end
        if (od !== fk(128'h1, 192'h0, 128'hDEADBEEF_00000000_CAFEF00D_12345678))
            begin errors++; $display("FAIL stale_out_data: got %h", od); end
        if (ol !== 1'b1) begin errors++; $display("FAIL stale_out_last: got %b required 1", ol); end
    endtask

    task automatic test_back_pressure();
        logic [191:0] k;
        logic [127:0] iv, d, held;
        logic         stable_ok, ready_low_ok;
        k  = 192'h01234567_89ABCDEF_FEDCBA98_76543210_0F0F0F0F_F0F0F0F0;
        iv = 128'h00112233_44556677_8899AABB_CCDDEEF0;
        lat = 3;
        stale_hold = 0;
        // Load together with a valid input: load must win and no block is taken.
        bus.cfg_load = 1'b1;
        bus.cfg_key  = k;
        bus.cfg_iv   = iv;
        bus.in_valid = 1'b1;
        bus.in_data  = 128'h0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL coinc_in_ready: got %b required 0", bus.in_ready); end
        tick();
        bus.cfg_load = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL coinc_busy: got %b required 0", bus.busy); end
        for (int i = 0; i < 4; i++) begin
            d = {4{32'h5555AAAA ^ 32'(i)}};
            run_block(d, (i == 3), (i != 0), s_arm, s_fire, st_wait, cyc, od, ol);
            checks += 3;
            if (od !== fk({iv[127:32], iv[31:0] + 32'(i)}, k, d))
                begin errors++; $display("FAIL bp_data_%0d: got %h", i, od); end
            if (ol !== (i == 3)) begin errors++; $display("FAIL bp_last_%0d: got %b required %b", i, ol, (i == 3)); end
            if (st_wait !== {iv[127:32], iv[31:0] + 32'(i)})
                begin errors++; $display("FAIL bp_ctr_%0d: got %h", i, st_wait); end
            if (i == 0) begin
                held = bus.out_data;
                stable_ok = 1'b1;
                ready_low_ok = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    tick();
                    if (bus.out_data !== held || bus.out_valid !== 1'b1) stable_ok = 1'b0;
                    if (bus.in_ready !== 1'b0) ready_low_ok = 1'b0;
                end
                checks += 3;
                if (stable_ok !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b required 1", stable_ok); end
                if (ready_low_ok !== 1'b1) begin errors++; $display("FAIL bp_in_ready_low: got %b required 1", ready_low_ok); end
                bus.out_ready = 1'b1;
                tick();
                bus.out_ready = 1'b0;
                if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after: got %b required 1", bus.in_ready); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [191:0] k;
        logic [127:0] iv;
        k  = 192'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4_E1E2E3E4_F1F2F3F4;
        iv = 128'hAABBCCDD_00000000_11111111_FFFFFFFF;
        lat = 4;
        load(k, iv);
        run_block(128'h1, 1'b0, 1'b1, s_arm, s_fire, st_wait, cyc, od, ol);
        checks += 2;
        if (st_wait !== iv) begin errors++; $display("FAIL wrap_ctr0: got %h required %h", st_wait, iv); end
        if (od !== fk(iv, k, 128'h1)) begin errors++; $display("FAIL wrap_data0: got %h", od); end
        run_block(128'h2, 1'b1, 1'b1, s_arm, s_fire, st_wait, cyc, od, ol);
        checks += 2;
        if (st_wait !== 128'hAABBCCDD_00000000_11111111_00000000)
            begin errors++; $display("FAIL wrap_ctr1: got %h required aabbccdd000000001111111100000000", st_wait); end
        if (od !== fk(128'hAABBCCDD_00000000_11111111_00000000, k, 128'h2))
            begin errors++; $display("FAIL wrap_data1: got %h", od); end
    endtask

    task automatic test_reset_mid_wait();
        logic no_out, no_ready;
        lat = 12;
        load(192'h5, 128'h77);
        send(128'h9, 1'b0);
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.core_start !== 1'b1)
            begin errors++; $display("FAIL mid_in_wait: busy=%b start=%b required 1 1", bus.busy, bus.core_start); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 3;
        if (bus.core_start !== 1'b0) begin errors++; $display("FAIL mid_start: got %b required 0", bus.core_start); end
        if (bus.busy !== 1'b0)       begin errors++; $display("FAIL mid_busy: got %b required 0", bus.busy); end
        if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL mid_in_ready: got %b required 0", bus.in_ready); end
        no_out = 1'b1;
        no_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.out_valid !== 1'b0) no_out = 1'b0;
            if (bus.in_ready !== 1'b0) no_ready = 1'b0;
        end
        bus.in_valid = 1'b0;
        checks += 3;
        if (no_out !== 1'b1)   begin errors++; $display("FAIL mid_no_out: got %b required 1", no_out); end
        if (no_ready !== 1'b1) begin errors++; $display("FAIL mid_no_ready: got %b required 1", no_ready); end
        load(192'h5, 128'h77);
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reload_ready: got %b required 1", bus.in_ready); end
    endtask

    task automatic test_cfg_load_busy();
        logic [191:0] k;
        logic [127:0] iv, d;
        int           n;
        k  = 192'h13579BDF_2468ACE0_0000FFFF_FFFF0000_12121212_34343434;
        iv = 128'h10000000_20000000_30000000_00000010;
        d  = 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE;
        lat = 6;
        load(k, iv);
        send(d, 1'b0);
        tick();
        tick();
        bus.cfg_load = 1'b1;
        bus.cfg_key  = 192'hFFFF;
        bus.cfg_iv   = 128'hFFFF_0000;
        tick();
        bus.cfg_load = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_data !== fk(iv, k, d)) begin errors++; $display("FAIL busy_load_data0: got %h", bus.out_data); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        run_block(d, 1'b1, 1'b1, s_arm, s_fire, st_wait, cyc, od, ol);
        checks += 2;
        if (st_wait !== 128'h10000000_20000000_30000000_00000011)
            begin errors++; $display("FAIL busy_load_ctr1: got %h required 10000000200000003000000000000011", st_wait); end
        if (od !== fk(128'h10000000_20000000_30000000_00000011, k, d))
            begin errors++; $display("FAIL busy_load_data1: got %h", od); end
    endtask

    initial begin
        bus.cfg_load  = 1'b0;
        bus.cfg_key   = '0;
        bus.cfg_iv    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_one_block();
        test_stale_valid();
        test_back_pressure();
        test_wrap();
        test_reset_mid_wait();
        test_cfg_load_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
